// File: rtl/capture_pkg.sv
// Shared types and defaults for the sample acquisition front end.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    OVF  = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic running;
    logic done;
    logic overflow;
  } cap_status_t;

  localparam int WIDTH_DEF = 16;
  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/sample_capture_if.sv
// Write side of the dual-clock sample FIFO: data, write strobe and full flag.
interface sample_capture_if
  import capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] sample_data;
  logic             sample_data_avail;
  logic             fifo_full;

  modport master (output sample_data, output sample_data_avail, input fifo_full);
  modport slave  (input sample_data, input sample_data_avail, output fifo_full);
endinterface

// File: rtl/probe_sync.sv
// Two-flop synchroniser, one independent chain per probe bit.
module probe_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [1:0][WIDTH-1:0] sync_pipe;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_pipe[0][i] <= 1'b0;
        sync_pipe[1][i] <= 1'b0;
      end else begin
        sync_pipe[0][i] <= d[i];
        sync_pipe[1][i] <= sync_pipe[0][i];
      end
    end
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/sample_capture.sv
// Acquisition front end: synchronise probes, decimate, mask and push words
// into the sample FIFO until a limit is reached or the FIFO overflows.
module sample_capture
  import capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  probe,
  input  logic              enable,
  input  logic [DIV_W-1:0]  divider,
  input  logic [WIDTH-1:0]  chan_mask,
  input  logic [CNT_W-1:0]  sample_limit,
  sample_capture_if.master  fifo,
  output logic              running,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  sample_count
);

  cap_state_e       state;
  cap_status_t      status;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] limit_q;
  logic [WIDTH-1:0] sync;
  logic             tick;
  logic [CNT_W-1:0] cnt_inc;
  logic             limit_hit;

  probe_sync #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (probe),
    .q   (sync)
  );

  assign tick      = (presc == '0);
  // Saturating increment: unlimited runs keep writing once the count pegs.
  assign cnt_inc   = (&sample_count) ? sample_count : sample_count + 1'b1;
  assign limit_hit = (limit_q != '0) && (cnt_inc == limit_q);

  assign running  = status.running;
  assign done     = status.done;
  assign overflow = status.overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      status                 <= '0;
      presc                  <= '0;
      div_q                  <= '0;
      limit_q                <= '0;
      sample_count           <= '0;
      fifo.sample_data       <= '0;
      fifo.sample_data_avail <= 1'b0;
    end else begin
      fifo.sample_data_avail <= 1'b0;
      case (state)
        IDLE: begin
          presc <= '0;
          if (enable) begin
            div_q          <= divider;
            limit_q        <= sample_limit;
            sample_count   <= '0;
            state          <= RUN;
            status.running <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            // A tick coinciding with enable dropping is discarded.
            state          <= IDLE;
            status.running <= 1'b0;
          end else begin
            presc <= (presc == div_q) ? '0 : presc + 1'b1;
            if (tick) begin
              if (fifo.fifo_full) begin
                state           <= OVF;
                status.running  <= 1'b0;
                status.overflow <= 1'b1;
              end else begin
                fifo.sample_data       <= sync & chan_mask;
                fifo.sample_data_avail <= 1'b1;
                sample_count           <= cnt_inc;
                if (limit_hit) begin
                  state          <= DONE;
                  status.running <= 1'b0;
                  status.done    <= 1'b1;
                end
              end
            end
          end
        end
        DONE, OVF: begin
          if (!enable) begin
            state           <= IDLE;
            status.done     <= 1'b0;
            status.overflow <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          status <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Randomised scoreboard bench for sample_capture against a cycle-count model.
module tb_sample_capture;
  import capture_pkg::*;

  localparam int W  = 16;
  localparam int DW = 16;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  probe;
  logic [W-1:0]  chan_mask;
  logic          enable;
  logic [DW-1:0] divider;
  logic [CW-1:0] sample_limit;
  logic          running, done, overflow;
  logic [CW-1:0] sample_count;

  sample_capture_if #(.WIDTH(W)) fif ();

  sample_capture #(.WIDTH(W), .DIV_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .probe        (probe),
    .enable       (enable),
    .divider      (divider),
    .chan_mask    (chan_mask),
    .sample_limit (sample_limit),
    .fifo         (fif.master),
    .running      (running),
    .done         (done),
    .overflow     (overflow),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_seen = 0;

  // Reference model: counts cycles since RUN entry; a sample is due whenever
  // that count is a multiple of the period.
  bit           m_act, m_run, m_done, m_ovf;
  int           m_k, m_period, m_limit, m_count;
  int           m_max = (1 << CW) - 1;
  logic [W-1:0] h1, h2, m_s, m_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_run = 0; m_done = 0; m_ovf = 0;
      m_k = 0; m_period = 1; m_limit = 0; m_count = 0;
      h1 = '0; h2 = '0; m_data = '0;
      q.delete();
    end else begin
      m_s = h2; h2 = h1; h1 = probe;
      cyc++;
      if (!m_act) begin
        if (enable) begin
          m_act = 1; m_run = 1;
          m_period = int'(divider) + 1;
          m_limit  = int'(sample_limit);
          m_count  = 0; m_k = 0;
        end
      end else if (!enable) begin
        m_act = 0; m_run = 0; m_done = 0; m_ovf = 0;
      end else if (m_run) begin
        if (m_k % m_period == 0) begin
          if (fif.fifo_full) begin
            m_run = 0; m_ovf = 1;
          end else begin
            m_data = m_s & chan_mask;
            q.push_back('{m_data, cyc});
            if (m_count < m_max) m_count++;
            if (m_limit != 0 && m_count == m_limit) begin
              m_run = 0; m_done = 1;
            end
          end
        end
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    chk("running", 64'(running), 64'(m_run));
    chk("done", 64'(done), 64'(m_done));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("sample_count", 64'(sample_count), 64'(m_count));
    chk("sample_data", 64'(fif.sample_data), 64'(m_data));
    if (fif.sample_data_avail === 1'b1) begin
      wr_seen++;
      if (q.size() == 0) begin
        chk("unexpected_strobe", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_data", 64'(fif.sample_data), 64'(e.data));
        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      chk("avail_low_or_pending", 64'(fif.sample_data_avail), 64'(0));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_case(input string nm);
    chk(nm, 64'(q.size()), 64'(0));
  endtask

  initial begin
    int base;
    rst = 1'b1; enable = 1'b0; probe = '0; chan_mask = '1;
    divider = '0; sample_limit = '0; fif.fifo_full = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);

    // steady pattern, back-to-back samples until the limit
    probe = 16'hA5C3; divider = 0; sample_limit = 4;
    step(3);
    enable = 1'b1;
    step(10);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_count", 64'(sample_count), 64'(4));
    chk("t1_data", 64'(fif.sample_data), 64'(16'hA5C3));
    enable = 1'b0; step(2); end_case("t1_queue");

    // decimation by 10
    divider = 9; sample_limit = 0; enable = 1'b1;
    step(100);
    chk("t2_count", 64'(sample_count), 64'(10));
    enable = 1'b0; step(2); end_case("t2_queue");

    // channel masking
    probe = 16'hFFFF; chan_mask = 16'h00F0; divider = 1; sample_limit = 6;
    step(3);
    enable = 1'b1; step(20);
    chk("t3_data", 64'(fif.sample_data), 64'(16'h00F0));
    chk("t3_done", 64'(done), 64'(1));
    enable = 1'b0; chan_mask = '1; step(2); end_case("t3_queue");

    // overflow after the second write
    divider = 3; sample_limit = 0; enable = 1'b1;
    base = wr_seen;
    for (int i = 0; i < 50 && wr_seen < base + 2; i++) step(1);
    chk("t4_two_writes", 64'(wr_seen - base), 64'(2));
    fif.fifo_full = 1'b1;
    step(10);
    chk("t4_overflow", 64'(overflow), 64'(1));
    chk("t4_count", 64'(sample_count), 64'(2));
    enable = 1'b0; step(1);
    chk("t4_ovf_clear", 64'(overflow), 64'(0));
    fif.fifo_full = 1'b0; step(1); end_case("t4_queue");

    // reset between ticks, then restart with enable held
    divider = 5; enable = 1'b1;
    step(5);
    rst = 1'b1;
    #1;
    chk("t5_rst_running", 64'(running), 64'(0));
    chk("t5_rst_count", 64'(sample_count), 64'(0));
    chk("t5_rst_avail", 64'(fif.sample_data_avail), 64'(0));
    step(2);
    rst = 1'b0;
    step(14);
    enable = 1'b0; step(2); end_case("t5_queue");

    // configuration changes ignored while running
    divider = 3; enable = 1'b1;
    step(6);
    divider = 0; step(12);
    enable = 1'b0; step(2);
    enable = 1'b1; step(8);
    enable = 1'b0; step(2); end_case("t6_queue");

    // unlimited run saturates the counter
    divider = 0; sample_limit = 0; enable = 1'b1;
    step(70);
    chk("t7_saturated", 64'(sample_count), 64'((1 << CW) - 1));
    enable = 1'b0; step(2); end_case("t7_queue");

    // random configurations with random probes, full and enable drops
    for (int c = 0; c < 10; c++) begin
      divider      = DW'($urandom_range(0, 4));
      sample_limit = CW'($urandom_range(0, 12));
      chan_mask    = W'($urandom);
      enable       = 1'b1;
      for (int i = 0; i < 40; i++) begin
        probe         = W'($urandom);
        fif.fifo_full = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 39) == 0) enable = ~enable;
        step(1);
      end
      enable = 1'b0; fif.fifo_full = 1'b0;
      step(2);
      end_case("rand_queue");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Acquisition front end on the fast sampling clock (`fastclk` domain).
- Synchronises the 16 `PROBE` inputs, decimates them with a programmable prescaler and masks disabled channels.
- Pushes words into the dual-clock sample FIFO through its `din`/`wr_en` pair, i.e. it drives `sample_data` and `sample_data_avail`.
- Stops on reaching a sample limit, or flags overflow when the FIFO is full at a write point.

Parameters:
- `WIDTH`, 16, probe/sample word width.
- `DIV_W`, 16, prescaler divider width.
- `CNT_W`, 32, sample counter and limit width.

Ports:
- `clk`  in  1  fastclk, sampling clock.
- `rst`  in  1  asynchronous, active-high reset.
- `probe`  in  `WIDTH`  raw asynchronous probe pins.
- `enable`  in  1  level; 1 = arm/run, 0 = stop and return to IDLE.
- `divider`  in  `DIV_W`  sample period minus 1, in clk cycles.
- `chan_mask`  in  `WIDTH`  1 = channel captured, 0 = forced to 0 in the sample.
- `sample_limit`  in  `CNT_W`  samples to take; 0 = unlimited.
- `fifo_full`  in  1  FIFO full flag, write-clock side.
- `sample_data`  out  `WIDTH`  word to FIFO `din`.
- `sample_data_avail`  out  1  one-cycle FIFO `wr_en` strobe.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `overflow`  out  1  high in OVF.
- `sample_count`  out  `CNT_W`  samples written since the last IDLE→RUN.

Behaviour:
- Reset (asynchronous, `rst`=1): state IDLE; synchroniser flops = 0; `sample_data` = 0; `sample_data_avail` = 0; prescaler = 0; `div_q` = 0; `limit_q` = 0; `sample_count` = 0; `running`, `done`, `overflow` = 0.
- Reset mid-acquisition: everything above clears immediately; no partial strobe is emitted.
- Synchroniser: two-flop on every `probe` bit, `sync = s2`. Latency from pin to `sync` is 2 clk.
- States: IDLE, RUN, DONE, OVF. All outputs are registered.
- IDLE:
  - prescaler held at 0.
  - When `enable`=1: latch `divider`→`div_q` and `sample_limit`→`limit_q`, clear `sample_count`, go to RUN.
- RUN:
  - `tick` = (prescaler==0).
  - Prescaler next value = 0 if prescaler==`div_q`, else prescaler+1.
  - The first tick occurs in the first RUN cycle. The period is `div_q`+1 cycles; `div_q`=0 means a tick every cycle.
  - On tick with `fifo_full`=0: next cycle `sample_data` = `sync` & `chan_mask`, `sample_data_avail` = 1, `sample_count` +1.
  - If `limit_q`≠0 and the new count equals `limit_q`: go to DONE in the same cycle as that write.
  - On tick with `fifo_full`=1: no write, go to OVF. The sample is lost; count is unchanged.
  - Off-tick cycles: `sample_data_avail` = 0; `sample_data` holds its last value.
- DONE / OVF: no writes; prescaler frozen; status held until `enable`=0.
- Any state with `enable`=0 → IDLE next cycle; `sample_count` is held (readable); `done`/`overflow` clear.
- Simultaneous events:
  - `enable` falling on a tick cycle: the tick is discarded, no write.
  - `fifo_full` together with the limit-reaching tick: OVF wins.
- `divider` and `sample_limit` changes during RUN are ignored until the next IDLE→RUN.
- `sample_count` saturates at all-ones when unlimited; writes continue.
- `sample_data_avail` is never high for two consecutive cycles unless `div_q`=0.

Decomposition:
- Shared package `capture_pkg`:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2, OVF=2'd3);
  - `WIDTH`/`DIV_W`/`CNT_W` defaults.
- Sub-module `probe_sync` (parameterised `WIDTH`-bit two-flop synchroniser with async reset). The FSM, prescaler and counter stay in `sample_capture`.

Test Plan:
- Synchroniser and first sample: `probe`=16'hA5C3 steady, `chan_mask`=16'hFFFF, `divider`=0, `sample_limit`=4, `enable`↑ → four consecutive strobes, each `sample_data`=16'hA5C3; then `done`=1, `sample_count`=4, no further strobes.
- Decimation: `divider`=9, `sample_limit`=0, run 100 cycles → strobes exactly 10 cycles apart, first one cycle after entering RUN; `sample_count`=10.
- Masking: `probe`=16'hFFFF, `chan_mask`=16'h00F0 → every `sample_data`=16'h00F0.
- Overflow: `divider`=3; assert `fifo_full` after the 2nd write → no 3rd strobe; `overflow`=1, `sample_count`=2; `enable`=0 → IDLE, `overflow`=0.
- Reset mid-run: `rst` pulse between ticks with `divider`=5 → all outputs 0 in the same cycle; after release with `enable`=1, restart with first strobe one cycle after RUN entry.
- Config isolation: change `divider` 3→0 during RUN → period stays 4 until `enable` toggles; after re-enable the period is 1.
